// File: rtl/mem_scan_pkg.sv
// Shared widths, buffer depth and sequencer state encoding for mem_scan_ctrl.
package mem_scan_pkg;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 18;
  localparam int LEN_W     = 9;
  localparam int SUM_W     = 26;
  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/mem_scan_ctrl_if.sv
// Command, memory-read and output-stream signals of mem_scan_ctrl.
// The master modport is the controller; the slave modport is its environment.
interface mem_scan_ctrl_if
  import mem_scan_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W,
  parameter int LW = LEN_W,
  parameter int SW = SUM_W
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic [AW-1:0] address;
  logic [DW-1:0] mem_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [SW-1:0] sum;

  modport master (
    input  start, base_addr, length, mem_data, out_ready,
    output address, out_valid, out_data, busy, done, sum
  );

  modport slave (
    output start, base_addr, length, mem_data, out_ready,
    input  address, out_valid, out_data, busy, done, sum
  );
endinterface

// File: rtl/mem_scan_ctrl_fifo.sv
// scan_fifo2: 2-entry first-word-fall-through FIFO; dout is the head, valid when !empty.
// Simultaneous push and pop keeps occupancy; a push into a full FIFO without a pop is dropped.
module scan_fifo2
  import mem_scan_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [OCC_W-1:0] occ,
  output logic             full,
  output logic             empty
);
  logic [W-1:0]     slot0_q, slot0_d;
  logic [W-1:0]     slot1_q, slot1_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    do_pop  = pop && (occ_q != '0);
    do_push = push && ((occ_q != OCC_W'(BUF_DEPTH)) || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (occ_q == '0) slot0_d = din;
        else             slot1_d = din;
        occ_d = occ_q + OCC_W'(1);
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - OCC_W'(1);
      end
      2'b11: begin
        // slot0 is leaving; the new word lands behind whatever remains
        if (occ_q == OCC_W'(1)) begin
          slot0_d = din;
        end else begin
          slot0_d = slot1_q;
          slot1_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
    end
  end

  assign dout  = slot0_q;
  assign occ   = occ_q;
  assign full  = (occ_q == OCC_W'(BUF_DEPTH));
  assign empty = (occ_q == '0);
endmodule

// File: rtl/mem_scan_ctrl.sv
// Walks a wrapping address range of a 1-cycle-latency memory and streams the words out with a running sum.
// First word valid 3 cycles after start; reads are credited against a 2-entry buffer so out_ready stalls lose nothing.
module mem_scan_ctrl
  import mem_scan_pkg::*;
#(
  parameter int ADDR_W = mem_scan_pkg::ADDR_W,
  parameter int DATA_W = mem_scan_pkg::DATA_W,
  parameter int LEN_W  = mem_scan_pkg::LEN_W,
  parameter int SUM_W  = mem_scan_pkg::SUM_W
) (
  input  logic            clk,
  input  logic            rst,
  mem_scan_ctrl_if.master bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              pending_q, pending_d;

  logic [DATA_W-1:0] fifo_dout;
  logic [OCC_W-1:0]  fifo_occ;
  logic              fifo_full, fifo_empty;
  logic              push, pop, issue;
  logic [2:0]        credit_used;
  logic [2:0]        occ_next;

  assign push = pending_q;
  assign pop  = bus.out_ready && !fifo_empty;

  // Words already buffered or in flight, minus the one leaving this cycle
  assign credit_used = 3'(fifo_occ) + 3'(pending_q) - 3'(pop);
  assign issue       = (state_q == RUN) && (credit_used < 3'(BUF_DEPTH));
  assign occ_next    = 3'(fifo_occ) + 3'(push) - 3'(pop);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    sum_d     = sum_q;
    pending_d = issue;
    if (pending_q) sum_d = sum_q + SUM_W'(bus.mem_data);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rem_d = bus.length;
          sum_d = '0;
          if (bus.length == '0) begin
            state_d = DONE;
          end else begin
            addr_d  = bus.base_addr;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Look ahead so done lands the cycle right after the final pop
        if ((occ_next == 3'd0) && !pending_d) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      sum_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      sum_q     <= sum_d;
      pending_q <= pending_d;
    end
  end

  scan_fifo2 #(.W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.mem_data),
    .dout  (fifo_dout),
    .occ   (fifo_occ),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.address   = addr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_dout;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.sum       = sum_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop))
    else $error("output buffer overflow");
endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Bench for mem_scan_ctrl: directed scenarios plus random scans checked by a queue scoreboard.
module tb_mem_scan_ctrl;
  import mem_scan_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_scan_ctrl_if bus ();

  mem_scan_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) bus.mem_data <= mem[bus.address];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] exp_q [$];
  logic [SUM_W-1:0]  exp_sum = '0;
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                done_base = 0;
  int                pop_cyc [$];
  logic [ADDR_W-1:0] addr_log [$];
  int                ready_mode = 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy && (addr_log.size() == 0 || bus.address != addr_log[$]))
        addr_log.push_back(bus.address);
      if (bus.out_valid && bus.out_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0d, required no word", bus.out_data);
        end else begin
          chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_sum", 32'(bus.sum), 32'(exp_sum));
        chk("done_drained", exp_q.size(), 0);
      end
    end
  end

  task automatic do_start(input logic [7:0] b, input logic [8:0] l, input bit accept, output int e0);
    @(negedge clk);
    if (accept) begin
      done_base = done_cnt;
      exp_sum   = '0;
      pop_cyc.delete();
      addr_log.delete();
      for (int i = 0; i < int'(l); i++) begin
        exp_q.push_back(mem[8'(int'(b) + i)]);
        exp_sum = exp_sum + SUM_W'(mem[8'(int'(b) + i)]);
      end
    end
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.length    = l;
    @(negedge clk);
    e0        = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == done_base) begin
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", budget);
    end
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e_dummy;
    logic [ADDR_W-1:0] a_before;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    for (int k = 0; k < 256; k++) mem[k] = DATA_W'(k);
    repeat (3) @(negedge clk);
    chk("rst_address", 32'(bus.address), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sum", 32'(bus.sum), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic latency and throughput
    do_start(8'd0, 9'd3, 1'b1, e0);
    wait_done(100);
    chk("t1_pops", pop_cyc.size(), 3);
    chk("t1_first_word_cycle", pop_cyc[0] - e0, 2);
    chk("t1_last_word_cycle", pop_cyc[2] - e0, 4);
    chk("t1_done_cycle", done_cyc - e0, 5);
    chk("t1_sum", 32'(bus.sum), 3);
    chk("t1_busy_low", 32'(bus.busy), 0);

    // Address wrap
    do_start(8'd254, 9'd4, 1'b1, e0);
    wait_done(100);
    chk("t2_addr0", 32'(addr_log[0]), 254);
    chk("t2_addr1", 32'(addr_log[1]), 255);
    chk("t2_addr2", 32'(addr_log[2]), 0);
    chk("t2_addr3", 32'(addr_log[3]), 1);
    chk("t2_sum", 32'(bus.sum), 510);

    // Back-pressure
    ready_mode = 0;
    @(negedge clk);
    do_start(8'd0, 9'd5, 1'b1, e0);
    repeat (10) @(negedge clk);
    chk("t3_addr_stall", 32'(bus.address), 2);
    chk("t3_out_valid", 32'(bus.out_valid), 1);
    chk("t3_head", 32'(bus.out_data), 0);
    chk("t3_occupancy", 32'(dut.u_fifo.occ_q), 2);
    chk("t3_no_pops", pop_cyc.size(), 0);
    ready_mode = 1;
    wait_done(100);
    chk("t3_sum", 32'(bus.sum), 10);
    repeat (5) @(negedge clk);
    chk("t3_done_once", done_cnt - done_base, 1);

    // Start while busy is ignored
    do_start(8'd10, 9'd6, 1'b1, e0);
    @(negedge clk);
    do_start(8'd100, 9'd3, 1'b0, e_dummy);
    wait_done(100);
    chk("t4_pops", pop_cyc.size(), 6);
    chk("t4_sum", 32'(bus.sum), 75);

    // Zero length
    a_before = bus.address;
    do_start(8'd77, 9'd0, 1'b1, e0);
    wait_done(20);
    chk("t5_done_cycle", done_cyc - e0, 0);
    chk("t5_addr_unchanged", 32'(bus.address), 32'(a_before));
    chk("t5_sum", 32'(bus.sum), 0);

    // Reset while a read is pending
    do_start(8'd0, 9'd10, 1'b1, e0);
    @(negedge clk);
    chk("t6_pending_before_rst", 32'(dut.pending_q), 1);
    rst = 1'b1;
    #1;
    chk("t6_out_valid", 32'(bus.out_valid), 0);
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_done", 32'(bus.done), 0);
    chk("t6_sum", 32'(bus.sum), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(8'd50, 9'd4, 1'b1, e0);
    wait_done(100);
    chk("t6_restart_sum", 32'(bus.sum), 206);
    chk("t6_restart_first", 32'(addr_log[0]), 50);

    // Random scans with random back-pressure and random memory contents
    ready_mode = 2;
    for (int it = 0; it < 15; it++) begin
      logic [7:0] rb;
      logic [8:0] rl;
      for (int k = 0; k < 256; k++) mem[k] = DATA_W'($urandom);
      rb = 8'($urandom_range(0, 255));
      rl = (it == 0) ? 9'd256 : 9'($urandom_range(0, 40));
      do_start(rb, rl, 1'b1, e0);
      wait_done(3000);
      chk("rnd_pops", pop_cyc.size(), 32'(rl));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
